// File: rtl/sc_mc_window_unit_if.sv
// Handshake bundle for sc_mc_window_unit: window/kernel request and per-channel result.
// The bipolar mode line is present only when SC_BIPOLAR_EN is defined.
interface sc_mc_window_unit_if #(
  parameter int unsigned BIN_LEN    = 8,
  parameter int unsigned SC_LEN_LOG = 8,
  parameter int unsigned K          = 3,
  parameter int unsigned CH         = 4,
  parameter int unsigned OUT_LEN    = SC_LEN_LOG + $clog2(K*K) + 1
);
  logic                       in_valid;
  logic                       in_ready;
  logic [K*K*BIN_LEN-1:0]     in_window;
  logic [CH*K*K*BIN_LEN-1:0]  in_weights;
  logic                       out_valid;
  logic                       out_ready;
  logic [CH*OUT_LEN-1:0]      out_vals;
  logic                       busy;
`ifdef SC_BIPOLAR_EN
  logic                       bipolar;
`endif

  modport master (
    output in_valid, in_window, in_weights, out_ready,
`ifdef SC_BIPOLAR_EN
    output bipolar,
`endif
    input  in_ready, out_valid, out_vals, busy
  );

  modport slave (
    input  in_valid, in_window, in_weights, out_ready,
`ifdef SC_BIPOLAR_EN
    input  bipolar,
`endif
    output in_ready, out_valid, out_vals, busy
  );
endinterface

// File: rtl/sc_mc_window_unit.sv
// Multi-channel stochastic K x K convolution: per-tap SC bitstreams, bitwise products,
// per-channel popcount accumulation over 2^SC_LEN_LOG cycles. Optional: SC_BIPOLAR_EN.
module sc_mc_window_unit #(
  parameter int unsigned BIN_LEN    = 8,
  parameter int unsigned SC_LEN_LOG = 8,
  parameter int unsigned K          = 3,
  parameter int unsigned CH         = 4,
  parameter int unsigned OUT_LEN    = SC_LEN_LOG + $clog2(K*K) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  sc_mc_window_unit_if.slave   bus
);
  localparam int unsigned TAPS   = K * K;
  localparam int unsigned SC_LEN = 1 << SC_LEN_LOG;
  localparam int unsigned PCW    = $clog2(TAPS + 1);
  localparam logic [OUT_LEN-1:0] BIP_OFFSET = OUT_LEN'(TAPS * SC_LEN);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                         state_q;
  logic [SC_LEN_LOG-1:0]          cnt_q;
  logic [TAPS*BIN_LEN-1:0]        win_q;
  logic [CH*TAPS*BIN_LEN-1:0]     wgt_q;
  logic [CH-1:0][OUT_LEN-1:0]     acc_q;
  logic [CH-1:0][OUT_LEN-1:0]     acc_d;
  logic [CH-1:0][OUT_LEN-1:0]     fin_d;
  logic [CH*OUT_LEN-1:0]          vals_q;
  logic                           bip_w;
  logic [SC_LEN_LOG-1:0]          rng_a;
  logic [SC_LEN_LOG-1:0]          rng_b;
  logic [TAPS-1:0]                pix_bit;
  logic                           wgt_bit;
  logic                           prod;
  logic [PCW-1:0]                 pc;

`ifdef SC_BIPOLAR_EN
  logic bip_q;
  assign bip_w = bip_q;
`else
  assign bip_w = 1'b0;
`endif

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q == RUN) || (state_q == DONE);
  assign bus.out_vals  = vals_q;

  // Pixel streams compare against the count, weight streams against its bit
  // reversal, so the two streams of one tap stay decorrelated.
  always_comb begin
    rng_a   = cnt_q;
    rng_b   = '0;
    pix_bit = '0;
    wgt_bit = 1'b0;
    prod    = 1'b0;
    pc      = '0;
    acc_d   = acc_q;
    fin_d   = '0;
    for (int unsigned i = 0; i < SC_LEN_LOG; i++) begin
      rng_b[i] = cnt_q[SC_LEN_LOG-1-i];
    end
    for (int unsigned t = 0; t < TAPS; t++) begin
      pix_bit[t] = rng_a < win_q[t*BIN_LEN + BIN_LEN - 1 -: SC_LEN_LOG];
    end
    for (int unsigned ch = 0; ch < CH; ch++) begin
      pc = '0;
      for (int unsigned t = 0; t < TAPS; t++) begin
        wgt_bit = rng_b < wgt_q[(ch*TAPS + t)*BIN_LEN + BIN_LEN - 1 -: SC_LEN_LOG];
        prod    = bip_w ? ~(pix_bit[t] ^ wgt_bit) : (pix_bit[t] & wgt_bit);
        pc      = pc + PCW'(prod);
      end
      acc_d[ch] = acc_q[ch] + OUT_LEN'(pc);
      fin_d[ch] = bip_w ? ((acc_d[ch] << 1) - BIP_OFFSET) : acc_d[ch];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      win_q   <= '0;
      wgt_q   <= '0;
      acc_q   <= '0;
      vals_q  <= '0;
`ifdef SC_BIPOLAR_EN
      bip_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            win_q   <= bus.in_window;
            wgt_q   <= bus.in_weights;
            acc_q   <= '0;
            cnt_q   <= '0;
`ifdef SC_BIPOLAR_EN
            bip_q   <= bus.bipolar;
`endif
            state_q <= RUN;
          end
        end
        RUN: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == '1) begin
            vals_q  <= fin_d;
            state_q <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/sc_mc_window_unit.md
# sc_mc_window_unit

Parametrised, multi-channel successor to the single-channel stochastic convolution processing unit. It accepts one K×K input window plus CH kernels per transaction over a valid/ready handshake. It generates deterministic stochastic bitstreams for every pixel and weight, multiplies them bitwise for all CH×K×K taps in parallel, and accumulates the product bits per channel with a binary parallel counter over SC_LEN = 2^SC_LEN_LOG cycles. It then returns CH binary results. It sits between the line-buffer/windowing stage upstream and the output writeback stage downstream.

## Interface
- BIN_LEN, 8, bit width of pixels and weights
- SC_LEN_LOG, 8, log2 of bitstream length; must satisfy SC_LEN_LOG ≤ BIN_LEN
- K, 3, kernel height and width
- CH, 4, output channel count
- OUT_LEN, SC_LEN_LOG + $clog2(K*K) + 1, per-channel result width (derived)
- clock  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- in_valid  in  1  window and weights present
- in_ready  out  1  block can accept (IDLE only)
- in_window  in  K*K*BIN_LEN  pixels; tap t = r*K+c at bits [t*BIN_LEN +: BIN_LEN]
- in_weights  in  CH*K*K*BIN_LEN  weights; channel ch, tap t at [(ch*K*K+t)*BIN_LEN +: BIN_LEN]
- out_valid  out  1  results available
- out_ready  in  1  downstream accepts results
- out_vals  out  CH*OUT_LEN  channel ch at [ch*OUT_LEN +: OUT_LEN]
- busy  out  1  high in RUN or DONE
- bipolar  in  1  (only with SC_BIPOLAR_EN) mode for the transaction; sampled at acceptance

## Operation
- FSM: IDLE → RUN → DONE → IDLE.
- IDLE: in_ready=1. On in_valid&&in_ready, the block:
  - registers in_window and in_weights (and bipolar, when present),
  - clears all CH accumulators and sc_count,
  - moves to RUN.
- RUN: in every cycle, with L=SC_LEN_LOG:
  - rng_a = sc_count and rng_b = bit-reverse(sc_count), both L bits.
  - Pixel bit = (rng_a < pixel[BIN_LEN-1 -: L]).
  - Weight bit = (rng_b < weight[BIN_LEN-1 -: L]).
  - Unipolar product = AND. Bipolar product = XNOR.
  - Each channel accumulator adds the popcount of its K*K product bits (0..K*K).
  - sc_count increments each cycle. On the cycle with sc_count == SC_LEN-1 the final add occurs and the FSM moves to DONE.
- DONE: out_valid=1 and out_vals is held stable. On out_ready, the FSM moves to IDLE; out_vals keeps its last value.
- Result, with ones = accumulated count:
  - Unipolar: out = ones, zero-extended.
  - Bipolar: out = 2*ones − K*K*SC_LEN, two's complement.
  - No saturation is needed; the range fits OUT_LEN by construction.
- in_valid is ignored outside IDLE. Input and weight ports may change freely after acceptance.

## Timing
- Reset values: in_ready=1, out_valid=0, busy=0, out_vals=0, sc_count=0, accumulators=0, state IDLE.
- Acceptance edge E0. RUN covers edges E1..E_SC_LEN. out_valid rises after E_SC_LEN.
- Latency from acceptance to out_valid is SC_LEN cycles.
- If out_ready is high when out_valid rises, DONE lasts 1 cycle. in_ready returns the following cycle.
- Peak throughput is one window per SC_LEN+2 cycles.
- out_ready held low stalls DONE indefinitely. Values and out_valid stay stable.
- Reset asserted mid-RUN or mid-DONE takes effect immediately and asynchronously: all outputs go to reset values and the partial result is discarded.
- sc_count wraps from SC_LEN-1 to 0 only on the RUN→DONE transition. No other wrap exists.

## Configuration
- SC_BIPOLAR_EN defined:
  - the bipolar port exists,
  - XNOR product and the signed offset result apply when bipolar is sampled as 1.
- SC_BIPOLAR_EN undefined:
  - the port is absent and the block is unipolar only (AND, zero-extended count),
  - out_vals has the same width.

## Test plan
- Reset then idle (defaults; with SC_BIPOLAR_EN, bipolar=0 unless stated) → in_ready=1, out_valid=0, out_vals=0, busy=0.
- All pixels 255, all weights 255, unipolar → 255 ones per tap; every channel = 2295; out_valid exactly 256 cycles after acceptance.
- All pixels 128, channel 0 weights 128, channel 1 weights 0, channels 2–3 weights 255, unipolar → ch0=576, ch1=0, ch2=ch3=1152.
- SC_BIPOLAR_EN, bipolar=1, pixels=weights=128 → all channels 0; pixels 255, weights 0 → 2*(9*1) − 2304 = −2286 per channel.
- out_ready held low 50 cycles after out_valid → out_vals stable, in_ready=0; a second in_valid is not accepted until out_ready is high for one cycle.
- Reset pulse at RUN cycle 100, then a new transaction with pixels=weights=255 → clean 2295 result, with no residue from the aborted run.
